fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control sequencer for the LC-3 instruction-fetch path. It drives the PC register's load enable and PCMUX select, the MAR/MDR/IR loads and the memory read strobe, and hands each fetched instruction to the execute control with a valid/done handshake. It also applies branch/jump PC redirects from execute and supports clean halting at instruction boundaries.

## Interface
Parameters:
- TIMEOUT, 15: maximum memory-wait cycles in FETCH2 before error; 0 disables the timeout.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  start fetching from IDLE.
- Halt  in  1  request stop at the next instruction boundary; latched.
- Mem_Ready  in  1  memory read data valid this cycle.
- Exec_Done  in  1  execute control finished the current instruction.
- Redirect  in  1  with Exec_Done: PC must be reloaded from a non-sequential source.
- Redirect_Src  in  1  with Exec_Done: 0 = address adder, 1 = bus.
- GatePC  out  1  drive PC onto the bus.
- LD_MAR  out  1  MAR load enable.
- LD_PC  out  1  PC register load enable.
- PCMUX  out  2  00 = PC+1, 01 = BUS, 10 = ADDR; 11 is never driven.
- Mem_OE  out  1  memory read strobe.
- LD_MDR  out  1  MDR load enable.
- LD_IR  out  1  IR load enable.
- IR_Valid  out  1  IR holds an instruction awaiting execution.
- Fetch_Err  out  1  sticky memory-timeout flag.
- State_Dbg  out  3  current state encoding, for hex display.

## Operation
- States: IDLE, FETCH1, FETCH2, FETCH3, EXEC, REDIR, ERR.
- IDLE: all strobes are 0. If Run=1 and halt_pending=0, go to FETCH1.
- FETCH1 (1 cycle): GatePC=LD_MAR=LD_PC=1 and PCMUX=00, so MAR<=PC and PC<=PC+1. Go to FETCH2.
- FETCH2: Mem_OE=1 and wait_cnt increments each cycle.
  - Mem_Ready=1: LD_MDR=1 in the same cycle (combinational on Mem_Ready), go to FETCH3.
  - TIMEOUT≠0, wait_cnt==TIMEOUT-1 and Mem_Ready=0: go to ERR.
  - wait_cnt clears on entry to FETCH2.
- FETCH3 (1 cycle): LD_IR=1. Go to EXEC.
- EXEC: IR_Valid=1. On Exec_Done=1:
  - Redirect=1: latch Redirect_Src, go to REDIR.
  - Otherwise: go to IDLE if halt_pending, else FETCH1.
- REDIR (1 cycle): LD_PC=1, PCMUX = latched_src ? 01 : 10. Then go to IDLE if halt_pending, else FETCH1.
- ERR: Fetch_Err=1, all other strobes 0. Held until Reset_n; Run is ignored.
- halt_pending:
  - Set by Halt=1 in any state.
  - Cleared on the cycle the FSM enters IDLE.
  - Halt and Run both high in IDLE: stay in IDLE.
- Redirect and Redirect_Src are ignored unless Exec_Done=1 in EXEC.
- Mem_Ready outside FETCH2 is ignored.
- Exec_Done outside EXEC is ignored.
- Counter width: $clog2(TIMEOUT+1), minimum 1; saturates, never wraps.

## Timing
- Reset: state=IDLE, halt_pending=0, latched_src=0, wait_cnt=0.
- Reset value of every output is 0, except State_Dbg = IDLE code 3'd0.
- All outputs decode from registered state, except LD_MDR (Mealy on Mem_Ready).
- Minimum instruction period is 4 cycles (FETCH1, FETCH2 with immediate Ready, FETCH3, EXEC with immediate Done). Add 1 cycle for a redirect and 1 per memory wait cycle.
- Run→FETCH1: 1 cycle after Run is sampled in IDLE.
- Reset_n low in any state forces IDLE immediately (asynchronous). In-flight strobes deassert with no completion.
- State codes: IDLE=0, FETCH1=1, FETCH2=2, FETCH3=3, EXEC=4, REDIR=5, ERR=7.

## Structure
- fetch_pkg: state enum fetch_state_t with the codes above; PCMUX localparams PCMUX_INC, PCMUX_BUS, PCMUX_ADDR.
- Optional sub-module mem_wait_timer: clear/enable/expired, parameterised by TIMEOUT.
- FSM and output decode live in fetch_sequencer.
- The 16-bit PC/MAR/MDR/IR registers stay in the datapath. This block carries no 16-bit data.

## Test plan
- Reset then Run=1, Mem_Ready high in FETCH2 cycle 1, Exec_Done on the first EXEC cycle → State_Dbg 0,1,2,3,4,1. LD_PC with PCMUX=00 in FETCH1, LD_MDR in FETCH2, LD_IR in FETCH3; next FETCH1 exactly 4 cycles later.
- Mem_Ready delayed 3 cycles → Mem_OE high for 4 cycles, a single LD_MDR pulse on the Ready cycle, FETCH3 follows.
- TIMEOUT=15 with Mem_Ready never asserted → ERR after 15 FETCH2 cycles, Fetch_Err=1 and stays 1. Run pulses are ignored; Reset_n low clears it to 0.
- Exec_Done with Redirect=1:
  - Redirect_Src=1 → REDIR cycle with LD_PC=1, PCMUX=01, then FETCH1.
  - Redirect_Src=0 → PCMUX=10.
- Halt pulsed for one cycle during FETCH2 → current instruction completes through EXEC, FSM enters IDLE rather than FETCH1, halt_pending clears. A later Run restarts fetching.
- Reset_n asserted mid-FETCH2 with Mem_OE=1 → Mem_OE drops the same instant and State_Dbg=0. No LD_MDR or LD_IR pulse follows release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state codes, PCMUX selects and counter sizing for the LC-3 fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_FETCH3 = 3'd3,
        ST_EXEC   = 3'd4,
        ST_REDIR  = 3'd5,
        ST_ERR    = 3'd7
    } fetch_state_t;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    // Wait counter width; a zero timeout still needs a one-bit register.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory-wait cycles and flags the last allowed one; TIMEOUT of 0 never expires.
module mem_wait_timer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] wait_cnt;

    // Saturating counter so a stuck memory can never wrap back under the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (wait_cnt == CNT_LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// LC-3 instruction-fetch control FSM: PC/MAR/MDR/IR strobes, execute handshake,
// PC redirects and halting at instruction boundaries.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Halt,
    input  logic       Mem_Ready,
    input  logic       Exec_Done,
    input  logic       Redirect,
    input  logic       Redirect_Src,
    output logic       GatePC,
    output logic       LD_MAR,
    output logic       LD_PC,
    output logic [1:0] PCMUX,
    output logic       Mem_OE,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       IR_Valid,
    output logic       Fetch_Err,
    output logic [2:0] State_Dbg
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic         halt_pending;
    logic         latched_src;
    logic         timer_expired;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .clear   (state == ST_FETCH1),
        .enable  (state == ST_FETCH2),
        .expired (timer_expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (Run && !halt_pending && !Halt) next_state = ST_FETCH1;
            ST_FETCH1: next_state = ST_FETCH2;
            ST_FETCH2: begin
                if (Mem_Ready)          next_state = ST_FETCH3;
                else if (timer_expired) next_state = ST_ERR;
            end
            ST_FETCH3: next_state = ST_EXEC;
            ST_EXEC: begin
                if (Exec_Done) begin
                    if (Redirect)          next_state = ST_REDIR;
                    else if (halt_pending) next_state = ST_IDLE;
                    else                   next_state = ST_FETCH1;
                end
            end
            ST_REDIR:  next_state = halt_pending ? ST_IDLE : ST_FETCH1;
            ST_ERR:    next_state = ST_ERR;
            default:   next_state = ST_IDLE;
        endcase
    end

    // A fresh Halt wins over the clear so a request arriving on the way into IDLE is kept.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_IDLE;
            halt_pending <= 1'b0;
            latched_src  <= 1'b0;
        end else begin
            state <= next_state;
            if (Halt)
                halt_pending <= 1'b1;
            else if (next_state == ST_IDLE)
                halt_pending <= 1'b0;
            if ((state == ST_EXEC) && Exec_Done && Redirect)
                latched_src <= Redirect_Src;
        end
    end

    always_comb begin
        GatePC    = 1'b0;
        LD_MAR    = 1'b0;
        LD_PC     = 1'b0;
        PCMUX     = PCMUX_INC;
        Mem_OE    = 1'b0;
        LD_MDR    = 1'b0;
        LD_IR     = 1'b0;
        IR_Valid  = 1'b0;
        Fetch_Err = 1'b0;
        case (state)
            ST_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            ST_FETCH2: begin
                Mem_OE = 1'b1;
                LD_MDR = Mem_Ready;
            end
            ST_FETCH3: LD_IR    = 1'b1;
            ST_EXEC:   IR_Valid = 1'b1;
            ST_REDIR: begin
                LD_PC = 1'b1;
                PCMUX = latched_src ? PCMUX_BUS : PCMUX_ADDR;
            end
            ST_ERR:    Fetch_Err = 1'b1;
            default:   ;
        endcase
    end

    assign State_Dbg = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scenario bench for fetch_sequencer: per-cycle expected output vectors go through a scoreboard queue.
module tb_fetch_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src;
    logic       GatePC, LD_MAR, LD_PC, Mem_OE, LD_MDR, LD_IR, IR_Valid, Fetch_Err;
    logic [1:0] PCMUX;
    logic [2:0] State_Dbg;

    logic [12:0] obs;
    logic [12:0] sb[$];
    logic [12:0] exp_v;
    int          n_cmp  = 0;
    int          n_fail = 0;

    fetch_sequencer #(.TIMEOUT(15)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .Halt         (Halt),
        .Mem_Ready    (Mem_Ready),
        .Exec_Done    (Exec_Done),
        .Redirect     (Redirect),
        .Redirect_Src (Redirect_Src),
        .GatePC       (GatePC),
        .LD_MAR       (LD_MAR),
        .LD_PC        (LD_PC),
        .PCMUX        (PCMUX),
        .Mem_OE       (Mem_OE),
        .LD_MDR       (LD_MDR),
        .LD_IR        (LD_IR),
        .IR_Valid     (IR_Valid),
        .Fetch_Err    (Fetch_Err),
        .State_Dbg    (State_Dbg)
    );

    always #5 Clk = ~Clk;

    assign obs = {State_Dbg, GatePC, LD_MAR, LD_PC, PCMUX, Mem_OE, LD_MDR, LD_IR, IR_Valid, Fetch_Err};

    // Expected outputs for a state, the current Mem_Ready and the redirect source latched in EXEC.
    function automatic logic [12:0] ev(input logic [2:0] st, input logic rdy, input logic lsrc);
        logic g, m, p, oe, md, ir, v, e;
        logic [1:0] mux;
        g = 0; m = 0; p = 0; oe = 0; md = 0; ir = 0; v = 0; e = 0; mux = 2'b00;
        case (st)
            3'd1: begin g = 1; m = 1; p = 1; end
            3'd2: begin oe = 1; md = rdy; end
            3'd3: ir = 1;
            3'd4: v = 1;
            3'd5: begin p = 1; mux = lsrc ? 2'b01 : 2'b10; end
            3'd7: e = 1;
            default: ;
        endcase
        return {st, g, m, p, mux, oe, md, ir, v, e};
    endfunction

    task automatic do_reset();
        {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = '0;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = 6'b101111;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(ev(3'd0, 1'b1, 1'b0));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b, expected %b", i, obs, exp_v);
            end
        end
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = '0;
        sb.push_back(ev(3'd0, 1'b0, 1'b0));
        @(negedge Clk);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release: got %b, expected %b", obs, exp_v);
        end
        @(posedge Clk);
        #1;
    endtask

    // Stimulus bits: {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src}; expectation {lsrc, state}.
    task automatic test_basic_fetch();
        logic [5:0] stim [9] = '{6'b001100, 6'b100000, 6'b000000, 6'b001000, 6'b000000,
                                 6'b000100, 6'b000000, 6'b001000, 6'b000000};
        logic [3:0] est  [9] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2, 4'h3};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = stim[i];
            sb.push_back(ev(est[i][2:0], stim[i][3], est[i][3]));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL basic[%0d]: got %b, expected %b", i, obs, exp_v);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [5:0] stim [9] = '{6'b100000, 6'b000000, 6'b000100, 6'b000000, 6'b000000,
                                 6'b001000, 6'b001000, 6'b000100, 6'b000000};
        logic [3:0] est  [9] = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h3, 4'h4, 4'h1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = stim[i];
            sb.push_back(ev(est[i][2:0], stim[i][3], est[i][3]));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mem_wait[%0d]: got %b, expected %b", i, obs, exp_v);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_timeout();
        logic [2:0] st;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            Run = (i == 0) || (i >= 17);
            st  = (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : (i <= 16) ? 3'd2 : 3'd7;
            sb.push_back(ev(st, 1'b0, 1'b0));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %b, expected %b", i, obs, exp_v);
            end
            @(posedge Clk);
            #1;
        end
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (Fetch_Err !== 1'b0 || State_Dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%b state=%0d, expected err=0 state=0", Fetch_Err, State_Dbg);
        end
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        Run = 1'b0;
    endtask

    task automatic test_redirect();
        logic [5:0] stim [13] = '{6'b100000, 6'b000000, 6'b001000, 6'b000000, 6'b000111,
                                  6'b000000, 6'b000000, 6'b001000, 6'b000000, 6'b000011,
                                  6'b000110, 6'b000001, 6'b000000};
        logic [3:0] est  [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hD, 4'h1, 4'h2, 4'h3,
                                  4'h4, 4'h4, 4'h5, 4'h1};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = stim[i];
            sb.push_back(ev(est[i][2:0], stim[i][3], est[i][3]));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL redirect[%0d]: got %b, expected %b", i, obs, exp_v);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_halt();
        logic [5:0] stim [14] = '{6'b100000, 6'b000000, 6'b010000, 6'b001000, 6'b000000,
                                  6'b000100, 6'b000000, 6'b000000, 6'b100000, 6'b000000,
                                  6'b001000, 6'b000000, 6'b000100, 6'b000000};
        logic [3:0] est  [14] = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0,
                                  4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        logic [5:0] stim2 [4] = '{6'b110000, 6'b000000, 6'b100000, 6'b000000};
        logic [3:0] est2  [4] = '{4'h0, 4'h0, 4'h0, 4'h1};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = stim[i];
            sb.push_back(ev(est[i][2:0], stim[i][3], est[i][3]));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL halt[%0d]: got %b, expected %b", i, obs, exp_v);
            end
            @(posedge Clk);
            #1;
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = stim2[i];
            sb.push_back(ev(est2[i][2:0], stim2[i][3], est2[i][3]));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL halt_run_idle[%0d]: got %b, expected %b", i, obs, exp_v);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [5:0] stim [3] = '{6'b100000, 6'b000000, 6'b000000};
        logic [3:0] est  [3] = '{4'h0, 4'h1, 4'h2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = stim[i];
            sb.push_back(ev(est[i][2:0], stim[i][3], est[i][3]));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_reset_pre[%0d]: got %b, expected %b", i, obs, exp_v);
            end
            @(posedge Clk);
            #1;
        end
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (Mem_OE !== 1'b0 || State_Dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got oe=%b state=%0d, expected oe=0 state=0", Mem_OE, State_Dbg);
        end
        {Mem_Ready, Exec_Done} = 2'b11;
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ev(3'd0, 1'b1, 1'b0));
            @(negedge Clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_reset_post[%0d]: got %b, expected %b", i, obs, exp_v);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        {Run, Halt, Mem_Ready, Exec_Done, Redirect, Redirect_Src} = '0;
        @(posedge Clk);
        #1;
        test_reset();
        test_basic_fetch();
        test_mem_wait();
        test_timeout();
        test_redirect();
        test_halt();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
